// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: occupancy counter width and a packed status word for downstream registers.
package fifo_pkg;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Storage is deliberately not reset so it maps onto plain flops or distributed RAM.
module fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [PW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [PW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO of any depth >= 2 with count, almost flags, sticky error flags and flush.
// Status is combinational from the count register; read data is registered (FWFT=0) or the live head (FWFT=1).
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    localparam int CW = fifo_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] write_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] read_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

    if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_params
        $error("sync_fifo_ext: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             rd_acc, wr_acc, mem_we;
    logic [WIDTH-1:0] head_dat;
    fifo_status_t     status;

    // Explicit wrap compare so non-power-of-2 depths use every entry.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        status              = '0;
        status.full         = (count_q == DEPTH_C);
        status.empty        = (count_q == '0);
        status.almost_full  = (count_q >= AF_C);
        status.almost_empty = (count_q <= AE_C);
        status.overflow     = ovf_q;
        status.underflow    = unf_q;
    end

    assign full_o         = status.full;
    assign empty_o        = status.empty;
    assign almost_full_o  = status.almost_full;
    assign almost_empty_o = status.almost_empty;
    assign overflow_o     = status.overflow;
    assign underflow_o    = status.underflow;
    assign count_o        = count_q;

    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign rd_acc = rd_en_i && !status.empty;
    assign wr_acc = wr_en_i && (!status.full || rd_acc);
    assign mem_we = wr_acc && rst_n && !flush_i;

    always_comb begin
        rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        ovf_d    = ovf_q || (wr_en_i && !wr_acc);
        unf_d    = unf_q || (rd_en_i && !rd_acc);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (mem_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (write_data_i),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head_dat)
    );

    if (FWFT != 0) begin : g_fwft
        assign read_data_o = head_dat;
    end else begin : g_reg
        logic [WIDTH-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (!rst_n || flush_i) begin
                rdata_q <= '0;
            end else if (rd_acc) begin
                rdata_q <= head_dat;
            end
        end
        assign read_data_o = rdata_q;
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Two DEPTH=5 instances (registered and FWFT read) driven in lockstep, checked against a queue model.
module tb_sync_fifo_ext;

    logic       clk = 1'b0;
    logic       rst_n, flush, wr_en, rd_en;
    logic [7:0] wdat;

    logic [7:0] r_rdata, f_rdata;
    logic       r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0] r_cnt, f_cnt;

    always #5 clk = ~clk;

    sync_fifo_ext #(.DEPTH(5), .WIDTH(8), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .wr_en_i(wr_en), .write_data_i(wdat),
        .rd_en_i(rd_en), .read_data_o(r_rdata), .full_o(r_full), .empty_o(r_empty),
        .almost_full_o(r_af), .almost_empty_o(r_ae), .count_o(r_cnt),
        .overflow_o(r_ovf), .underflow_o(r_unf)
    );

    sync_fifo_ext #(.DEPTH(5), .WIDTH(8), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .wr_en_i(wr_en), .write_data_i(wdat),
        .rd_en_i(rd_en), .read_data_o(f_rdata), .full_o(f_full), .empty_o(f_empty),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_cnt),
        .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    // Reference model: a plain queue of words plus sticky flags and the last popped word.
    logic [7:0] mq[$];
    logic       m_ovf, m_unf;
    logic [7:0] m_last;
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic cyc(input bit rs_n, input bit fl, input bit wr, input logic [7:0] d, input bit rd);
        bit rd_ok, wr_ok;
        rst_n = rs_n; flush = fl; wr_en = wr; wdat = d; rd_en = rd;
        @(posedge clk);
        if (!rs_n || fl) begin
            mq.delete(); m_ovf = 0; m_unf = 0; m_last = 8'h00;
        end else begin
            rd_ok = rd && (mq.size() > 0);
            wr_ok = wr && ((mq.size() < 5) || rd_ok);
            if (rd && !rd_ok) m_unf = 1;
            if (wr && !wr_ok) m_ovf = 1;
            if (rd_ok) m_last = mq.pop_front();
            if (wr_ok) mq.push_back(d);
        end
        #1;
        rst_n = 1; flush = 0; wr_en = 0; rd_en = 0;
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h5A, 1);
        n_checks++; if (r_cnt !== 3'd0) $display("FAIL reset_count got %0d exp 0", r_cnt); else n_pass++;
        n_checks++; if ({r_empty, r_full, r_ae, r_af} !== 4'b1010)
            $display("FAIL reset_flags got %b exp 1010", {r_empty, r_full, r_ae, r_af}); else n_pass++;
        n_checks++; if ({r_ovf, r_unf, f_ovf, f_unf} !== 4'b0000)
            $display("FAIL reset_sticky got %b exp 0000", {r_ovf, r_unf, f_ovf, f_unf}); else n_pass++;
        n_checks++; if (r_rdata !== 8'h00) $display("FAIL reset_rdata got %h exp 00", r_rdata); else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 0, 1, 8'(k * 8'h11), 0);
            n_checks++; if (r_cnt !== 3'(k)) $display("FAIL fill_count got %0d exp %0d", r_cnt, k); else n_pass++;
            n_checks++; if (r_af !== (k >= 4)) $display("FAIL fill_af got %b exp %b", r_af, k >= 4); else n_pass++;
        end
        n_checks++; if (r_full !== 1'b1 || f_full !== 1'b1)
            $display("FAIL fill_full got %b/%b exp 1/1", r_full, f_full); else n_pass++;
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 0, 0, 8'h00, 1);
            n_checks++; if (r_rdata !== 8'(k * 8'h11))
                $display("FAIL drain_rdata got %h exp %h", r_rdata, 8'(k * 8'h11)); else n_pass++;
        end
        n_checks++; if (r_empty !== 1'b1 || r_cnt !== 3'd0)
            $display("FAIL drain_empty got %b cnt %0d exp 1 cnt 0", r_empty, r_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        bit rd;
        for (int i = 0; i < 12; i++) begin
            rd = (mq.size() >= 4) || ((mq.size() >= 3) && ($urandom_range(0, 1) == 1));
            cyc(1, 0, 1, 8'($urandom), rd);
            n_checks++; if (r_cnt !== 3'(mq.size())) $display("FAIL wrap_count got %0d exp %0d", r_cnt, mq.size()); else n_pass++;
            n_checks++; if (r_rdata !== m_last) $display("FAIL wrap_rdata got %h exp %h", r_rdata, m_last); else n_pass++;
            n_checks++; if (f_rdata !== mq[0]) $display("FAIL wrap_head got %h exp %h", f_rdata, mq[0]); else n_pass++;
            n_checks++; if ({r_ovf, r_unf} !== 2'b00) $display("FAIL wrap_sticky got %b exp 00", {r_ovf, r_unf}); else n_pass++;
        end
        while (mq.size() > 0) begin
            cyc(1, 0, 0, 8'h00, 1);
            n_checks++; if (r_rdata !== m_last) $display("FAIL wrap_drain got %h exp %h", r_rdata, m_last); else n_pass++;
        end
        n_checks++; if (r_empty !== 1'b1 || r_unf !== 1'b0)
            $display("FAIL wrap_end got empty %b unf %b exp 1 0", r_empty, r_unf); else n_pass++;
    endtask

    task automatic test_full_rw();
        for (int k = 1; k <= 5; k++) cyc(1, 0, 1, 8'(k), 0);
        cyc(1, 0, 1, 8'h66, 1);
        n_checks++; if (r_cnt !== 3'd5 || r_ovf !== 1'b0)
            $display("FAIL fullrw_both got cnt %0d ovf %b exp 5 0", r_cnt, r_ovf); else n_pass++;
        n_checks++; if (r_rdata !== 8'h01) $display("FAIL fullrw_pop got %h exp 01", r_rdata); else n_pass++;
        cyc(1, 0, 1, 8'h77, 0);
        n_checks++; if (r_ovf !== 1'b1 || r_cnt !== 3'd5)
            $display("FAIL fullrw_ovf got ovf %b cnt %0d exp 1 5", r_ovf, r_cnt); else n_pass++;
        for (int k = 0; k < 5; k++) cyc(1, 0, 0, 8'h00, 1);
        n_checks++; if (r_rdata !== 8'h66) $display("FAIL fullrw_last got %h exp 66", r_rdata); else n_pass++;
        n_checks++; if (r_ovf !== 1'b1) $display("FAIL fullrw_sticky got %b exp 1", r_ovf); else n_pass++;
    endtask

    task automatic test_empty_rw();
        cyc(1, 0, 1, 8'hA5, 1);
        n_checks++; if (r_unf !== 1'b1 || f_unf !== 1'b1)
            $display("FAIL emptyrw_unf got %b/%b exp 1/1", r_unf, f_unf); else n_pass++;
        n_checks++; if (r_cnt !== 3'd1) $display("FAIL emptyrw_count got %0d exp 1", r_cnt); else n_pass++;
        n_checks++; if (r_rdata !== 8'h66) $display("FAIL emptyrw_hold got %h exp 66", r_rdata); else n_pass++;
        n_checks++; if (f_rdata !== 8'hA5) $display("FAIL emptyrw_fwft got %h exp a5", f_rdata); else n_pass++;
    endtask

    task automatic test_flush();
        cyc(1, 0, 1, 8'h01, 0);
        cyc(1, 0, 1, 8'h02, 0);
        n_checks++; if ({r_cnt, r_ovf, r_unf} !== {3'd3, 2'b11})
            $display("FAIL flush_pre got cnt %0d flags %b exp 3 11", r_cnt, {r_ovf, r_unf}); else n_pass++;
        cyc(1, 1, 1, 8'hEE, 0);
        n_checks++; if (r_cnt !== 3'd0 || r_empty !== 1'b1 || f_cnt !== 3'd0)
            $display("FAIL flush_count got %0d/%0d empty %b exp 0 1", r_cnt, f_cnt, r_empty); else n_pass++;
        n_checks++; if ({r_ovf, r_unf, f_ovf, f_unf} !== 4'b0000)
            $display("FAIL flush_sticky got %b exp 0000", {r_ovf, r_unf, f_ovf, f_unf}); else n_pass++;
        cyc(1, 0, 1, 8'h7E, 0);
        n_checks++; if (f_rdata !== 8'h7E || f_cnt !== 3'd1)
            $display("FAIL flush_fwft got %h cnt %0d exp 7e 1", f_rdata, f_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) cyc(1, 0, 1, 8'(8'hC0 + k), 0);
        n_checks++; if (r_cnt !== 3'd4) $display("FAIL rstmid_pre got %0d exp 4", r_cnt); else n_pass++;
        cyc(0, 0, 0, 8'h00, 1);
        n_checks++; if ({r_cnt, r_empty, r_full, r_ae, r_af, r_ovf, r_unf} !== {3'd0, 6'b101000})
            $display("FAIL rstmid_state got %b exp 000101000",
                     {r_cnt, r_empty, r_full, r_ae, r_af, r_ovf, r_unf}); else n_pass++;
        n_checks++; if (r_rdata !== 8'h00) $display("FAIL rstmid_rdata got %h exp 00", r_rdata); else n_pass++;
    endtask

    task automatic test_random();
        int sz;
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 120) != 0), ($urandom_range(0, 40) == 0),
                ($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 1) == 1));
            sz = mq.size();
            n_checks++; if (r_cnt !== 3'(sz) || f_cnt !== 3'(sz))
                $display("FAIL rand_count got %0d/%0d exp %0d", r_cnt, f_cnt, sz); else n_pass++;
            n_checks++; if ({r_full, r_empty, r_af, r_ae} !== {sz == 5, sz == 0, sz >= 4, sz <= 1})
                $display("FAIL rand_flags got %b exp %b", {r_full, r_empty, r_af, r_ae},
                         {sz == 5, sz == 0, sz >= 4, sz <= 1}); else n_pass++;
            n_checks++; if ({r_ovf, r_unf} !== {m_ovf, m_unf})
                $display("FAIL rand_sticky got %b exp %b", {r_ovf, r_unf}, {m_ovf, m_unf}); else n_pass++;
            n_checks++; if (r_rdata !== m_last) $display("FAIL rand_rdata got %h exp %h", r_rdata, m_last); else n_pass++;
            if (sz > 0) begin
                n_checks++; if (f_rdata !== mq[0]) $display("FAIL rand_head got %h exp %h", f_rdata, mq[0]); else n_pass++;
            end
        end
    endtask

    initial begin
        rst_n = 0; flush = 0; wr_en = 0; rd_en = 0; wdat = 8'h00;
        m_ovf = 0; m_unf = 0; m_last = 8'h00;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_rw();
        test_empty_rw();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised synchronous FIFO for the audio capture path (I2S samples to SPI/readout side). It supersedes the basic sample FIFO with these additions:
- any depth, including non-power-of-2
- full use of all DEPTH entries
- occupancy count
- programmable almost-full and almost-empty flags
- sticky overflow and underflow flags
- synchronous flush
- selectable first-word-fall-through (FWFT) read mode

Single clock domain.

Parameters:
- DEPTH, 8: number of storage entries; any integer >= 2.
- WIDTH, 8: data word width in bits; >= 1.
- FWFT, 0: 0 = registered read (data one cycle after pop); 1 = head word visible on read_data_o while !empty_o.
- AF_THRESH, DEPTH-1: almost_full_o asserted when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 1: almost_empty_o asserted when count <= AE_THRESH; range 0..DEPTH-1.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- flush_i, input, 1: synchronous clear of FIFO state.
- wr_en_i, input, 1: write request.
- write_data_i, input, WIDTH: write data.
- rd_en_i, input, 1: read (pop) request.
- read_data_o, output, WIDTH: read data.
- full_o, output, 1: count == DEPTH.
- empty_o, output, 1: count == 0.
- almost_full_o, output, 1: count >= AF_THRESH.
- almost_empty_o, output, 1: count <= AE_THRESH.
- count_o, output, CW = $clog2(DEPTH+1): current occupancy.
- overflow_o, output, 1: sticky; a write was rejected.
- underflow_o, output, 1: sticky; a read was rejected.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - rd_ptr, wr_ptr, count = 0
  - read_data_o = 0 (FWFT=0)
  - overflow_o, underflow_o = 0
  - hence empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0
  - Memory contents are not reset.
- Priority order: reset > flush_i > rd/wr.
  - flush_i=1 has the same effect as reset except memory is untouched.
  - wr_en_i and rd_en_i are ignored in the flush cycle.
- Read accept: rd_acc = rd_en_i && !empty_o.
- Write accept: wr_acc = wr_en_i && (!full_o || rd_acc). A write while full succeeds if a pop is accepted in the same cycle.
- Empty with simultaneous rd/wr: read rejected (underflow set), write accepted. No bypass in either mode.
- Pointers: increment on accept; DEPTH-1 wraps to 0 (explicit compare, not power-of-2 overflow).
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
- Status outputs: full_o, empty_o, almost_* and count_o are combinational from the count register.
  - They reflect state after the last edge.
  - Zero-cycle latency from register to flag.
- Write-to-read latency: a word written at edge N is poppable from edge N+1 (empty_o deasserts after edge N).
- FWFT=0:
  - read_data_o is a register loaded with mem[rd_ptr] at the edge where rd_acc=1.
  - It holds its value otherwise, including on a rejected read (never cleared to 0).
- FWFT=1:
  - read_data_o = mem[rd_ptr] combinationally; it is valid only while !empty_o.
  - rd_acc advances to the next word.
- Sticky flags:
  - overflow_o set at the edge where wr_en_i && !wr_acc.
  - underflow_o set at the edge where rd_en_i && !rd_acc.
  - Both cleared only by reset or flush_i.
- Static parameter checks via elaboration-time assertion: AF_THRESH in 1..DEPTH, AE_THRESH in 0..DEPTH-1, DEPTH >= 2.

Decomposition:
- Shared package fifo_pkg:
  - function fifo_cnt_w(depth) returning $clog2(depth+1)
  - typedef fifo_status_t, a packed struct {full, empty, almost_full, almost_empty, overflow, underflow} for downstream status registers
- One sub-module fifo_mem:
  - simple dual-port register array
  - synchronous write port, asynchronous read port
  - parameters DEPTH, WIDTH
- sync_fifo_ext holds pointers, count, flags and the FWFT output mux.

Test Plan:
1. DEPTH=5, FWFT=0: after reset, write 0x11..0x55 on 5 consecutive cycles -> full_o=1, count_o=5, almost_full_o=1 from count 4. Then pop 5 times -> read_data_o=0x11..0x55, each one cycle after its pop; empty_o=1 at end.
2. DEPTH=5: write 12 words, reading as needed to keep count between 2 and 4 -> pointers wrap twice; data order preserved; overflow_o=0 and underflow_o=0 throughout.
3. When full (count=5), assert wr_en_i+rd_en_i with data 0x66 -> count stays 5, overflow_o=0, 0x66 read out last. Then wr_en_i alone -> overflow_o=1 and stays 1.
4. When empty, assert rd_en_i+wr_en_i with 0xA5 -> underflow_o=1, count_o=1. FWFT=0: read_data_o keeps its previous value. FWFT=1: read_data_o=0xA5 on the next cycle.
5. With count=3 and both sticky flags set, pulse flush_i while wr_en_i=1 -> count_o=0, empty_o=1, flags=0, write ignored. Then write 0x7E, FWFT=1 -> read_data_o=0x7E one cycle later.
6. With count=4, assert rst_n=0 mid-stream with rd_en_i=1 -> all outputs at reset values the following cycle; read_data_o=0.
